// File: rtl/pipeline_hazard_ctrl_if.sv
// -----------------------------------------------------------------------------
// pipeline_hazard_ctrl_if
// Bundles every signal exchanged between the 5-stage pipeline datapath and the
// hazard controller.
//   master : pipeline side. Drives the stage register/destination info and the
//            data-memory handshake, and receives the stage controls.
//   slave  : hazard controller side.
// Signals:
//   id_rs1/id_rs2, id_use_rs1/id_use_rs2      ID source operands
//   ex_rs1/ex_rs2, ex_rd, ex_ru_write,
//   ex_ru_data_src, ex_branch_taken           EX stage info
//   me_rd, me_ru_write, me_dm_req, dm_ready   ME stage info + memory handshake
//   wb_rd, wb_ru_write                        WB stage info
//   pc_en .. me_wb_en                         stage advance enables
//   if_id_flush, id_ex_flush                  bubble insertion
//   fwd_a, fwd_b                              ALU operand forwarding selects
//   mem_timeout                               sticky memory timeout error
//   stall_count, flush_count                  saturating statistics
// -----------------------------------------------------------------------------
interface pipeline_hazard_ctrl_if #(
    parameter int CNT_W = 16
);
    logic [4:0]       id_rs1;
    logic [4:0]       id_rs2;
    logic             id_use_rs1;
    logic             id_use_rs2;
    logic [4:0]       ex_rs1;
    logic [4:0]       ex_rs2;
    logic [4:0]       ex_rd;
    logic             ex_ru_write;
    logic [1:0]       ex_ru_data_src;
    logic             ex_branch_taken;
    logic [4:0]       me_rd;
    logic             me_ru_write;
    logic             me_dm_req;
    logic             dm_ready;
    logic [4:0]       wb_rd;
    logic             wb_ru_write;
    logic             pc_en;
    logic             if_id_en;
    logic             id_ex_en;
    logic             ex_me_en;
    logic             me_wb_en;
    logic             if_id_flush;
    logic             id_ex_flush;
    logic [1:0]       fwd_a;
    logic [1:0]       fwd_b;
    logic             mem_timeout;
    logic [CNT_W-1:0] stall_count;
    logic [CNT_W-1:0] flush_count;

    modport master (
        output id_rs1, id_rs2, id_use_rs1, id_use_rs2,
        output ex_rs1, ex_rs2, ex_rd, ex_ru_write, ex_ru_data_src, ex_branch_taken,
        output me_rd, me_ru_write, me_dm_req, dm_ready, wb_rd, wb_ru_write,
        input  pc_en, if_id_en, id_ex_en, ex_me_en, me_wb_en,
        input  if_id_flush, id_ex_flush, fwd_a, fwd_b,
        input  mem_timeout, stall_count, flush_count
    );

    modport slave (
        input  id_rs1, id_rs2, id_use_rs1, id_use_rs2,
        input  ex_rs1, ex_rs2, ex_rd, ex_ru_write, ex_ru_data_src, ex_branch_taken,
        input  me_rd, me_ru_write, me_dm_req, dm_ready, wb_rd, wb_ru_write,
        output pc_en, if_id_en, id_ex_en, ex_me_en, me_wb_en,
        output if_id_flush, id_ex_flush, fwd_a, fwd_b,
        output mem_timeout, stall_count, flush_count
    );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// pipeline_hazard_ctrl
// Central stall / flush / forwarding controller of the 5-stage pipeline.
// Drives the stage register enables and bubble flushes, selects ALU operand
// forwarding, sequences multi-cycle data-memory accesses (RUN / MEM_WAIT /
// ERROR) with a timeout, and keeps saturating stall and flush statistics.
// Ports:
//   clk    pipeline clock, all state on posedge
//   rst_n  synchronous active-low reset
//   hz     pipeline_hazard_ctrl_if.slave, see the interface for signal list
// Stage controls and forwarding selects are combinational from the current
// state and inputs so they act in the same cycle as the hazard; the FSM,
// timeout flag and statistics are registered.
// -----------------------------------------------------------------------------
module pipeline_hazard_ctrl #(
    parameter int MAX_WAIT = 16,
    parameter int CNT_W    = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    pipeline_hazard_ctrl_if.slave hz
);
    localparam int                WAIT_W     = $clog2(MAX_WAIT + 1);
    localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(MAX_WAIT);
    localparam logic [CNT_W-1:0]  CNT_MAX    = {CNT_W{1'b1}};

    typedef enum logic [1:0] {
        ST_RUN      = 2'b00,
        ST_MEM_WAIT = 2'b01,
        ST_ERROR    = 2'b10
    } state_t;

    state_t            state_r;
    logic [WAIT_W-1:0] wait_cnt_r;
    logic              mem_timeout_r;
    logic [CNT_W-1:0]  stall_cnt_r;
    logic [CNT_W-1:0]  flush_cnt_r;

    logic freeze_s;
    logic load_use_match_s;
    logic branch_flush_s;
    logic load_use_stall_s;

    // Operand select: ME result beats WB value; x0 is never forwarded.
    function automatic logic [1:0] fwd_sel(
        input logic [4:0] rs,
        input logic [4:0] me_dst,
        input logic       me_wr,
        input logic [4:0] wb_dst,
        input logic       wb_wr
    );
        if (me_wr && (me_dst != 5'd0) && (me_dst == rs)) begin
            fwd_sel = 2'b10;
        end else if (wb_wr && (wb_dst != 5'd0) && (wb_dst == rs)) begin
            fwd_sel = 2'b01;
        end else begin
            fwd_sel = 2'b00;
        end
    endfunction

    // Hazard classification with priority freeze > branch flush > load-use.
    always_comb begin
        freeze_s = 1'b1;
        case (state_r)
            ST_RUN:      freeze_s = hz.me_dm_req && !hz.dm_ready;
            ST_MEM_WAIT: freeze_s = !hz.dm_ready;
            ST_ERROR:    freeze_s = 1'b1;
            default:     freeze_s = 1'b1;
        endcase
        load_use_match_s = hz.ex_ru_write && (hz.ex_ru_data_src == 2'b01) &&
                           (hz.ex_rd != 5'd0) &&
                           ((hz.id_use_rs1 && (hz.id_rs1 == hz.ex_rd)) ||
                            (hz.id_use_rs2 && (hz.id_rs2 == hz.ex_rd)));
        branch_flush_s   = !freeze_s && hz.ex_branch_taken;
        // A taken branch squashes the ID instruction, so its load-use is moot.
        load_use_stall_s = !freeze_s && !hz.ex_branch_taken && load_use_match_s;
    end

    // Stage enables, flushes and forwarding selects.
    always_comb begin
        hz.pc_en       = 1'b1;
        hz.if_id_en    = 1'b1;
        hz.id_ex_en    = 1'b1;
        hz.ex_me_en    = 1'b1;
        hz.me_wb_en    = 1'b1;
        hz.if_id_flush = 1'b0;
        hz.id_ex_flush = 1'b0;
        hz.fwd_a       = 2'b00;
        hz.fwd_b       = 2'b00;
        if (!rst_n) begin
            hz.pc_en       = 1'b0;
            hz.if_id_en    = 1'b0;
            hz.id_ex_en    = 1'b0;
            hz.ex_me_en    = 1'b0;
            hz.me_wb_en    = 1'b0;
            hz.if_id_flush = 1'b1;
            hz.id_ex_flush = 1'b1;
        end else begin
            hz.fwd_a = fwd_sel(hz.ex_rs1, hz.me_rd, hz.me_ru_write, hz.wb_rd, hz.wb_ru_write);
            hz.fwd_b = fwd_sel(hz.ex_rs2, hz.me_rd, hz.me_ru_write, hz.wb_rd, hz.wb_ru_write);
            if (freeze_s) begin
                hz.pc_en    = 1'b0;
                hz.if_id_en = 1'b0;
                hz.id_ex_en = 1'b0;
                hz.ex_me_en = 1'b0;
                hz.me_wb_en = 1'b0;
            end else if (branch_flush_s) begin
                hz.if_id_flush = 1'b1;
                hz.id_ex_flush = 1'b1;
            end else if (load_use_stall_s) begin
                // Hold PC and IF/ID, let the load move on, bubble into EX.
                hz.pc_en       = 1'b0;
                hz.if_id_en    = 1'b0;
                hz.id_ex_flush = 1'b1;
            end else begin
                hz.if_id_flush = 1'b0;
            end
        end
    end

    // Memory wait FSM, timeout flag and saturating statistics.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r       <= ST_RUN;
            wait_cnt_r    <= '0;
            mem_timeout_r <= 1'b0;
            stall_cnt_r   <= '0;
            flush_cnt_r   <= '0;
        end else begin
            case (state_r)
                ST_RUN: begin
                    if (hz.me_dm_req && !hz.dm_ready) begin
                        state_r    <= ST_MEM_WAIT;
                        wait_cnt_r <= WAIT_W'(1);
                    end
                end
                ST_MEM_WAIT: begin
                    if (hz.dm_ready) begin
                        state_r    <= ST_RUN;
                        wait_cnt_r <= '0;
                    end else if (wait_cnt_r == WAIT_LIMIT) begin
                        state_r       <= ST_ERROR;
                        mem_timeout_r <= 1'b1;
                    end else begin
                        wait_cnt_r <= wait_cnt_r + WAIT_W'(1);
                    end
                end
                ST_ERROR: begin
                    state_r <= ST_ERROR;
                end
                default: begin
                    // Corrupted state encoding is treated as a fatal error.
                    state_r       <= ST_ERROR;
                    mem_timeout_r <= 1'b1;
                end
            endcase
            if ((freeze_s || load_use_stall_s) && (stall_cnt_r != CNT_MAX)) begin
                stall_cnt_r <= stall_cnt_r + CNT_W'(1);
            end
            if (branch_flush_s && (flush_cnt_r != CNT_MAX)) begin
                flush_cnt_r <= flush_cnt_r + CNT_W'(1);
            end
        end
    end

    assign hz.mem_timeout = mem_timeout_r;
    assign hz.stall_count = stall_cnt_r;
    assign hz.flush_count = flush_cnt_r;
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pipeline_hazard_ctrl
// Self-checking bench: reset check, a table of single-cycle vectors, hand
// sequences for multi-cycle corners, then randomized traffic checked against a
// behavioural model. DUT built with MAX_WAIT=4 and CNT_W=4.
// -----------------------------------------------------------------------------
module tb_pipeline_hazard_ctrl;
    localparam int MAX_WAIT = 4;
    localparam int CNT_W    = 4;
    localparam int CNT_SAT  = (1 << CNT_W) - 1;

    logic clk;
    logic rst_n;

    pipeline_hazard_ctrl_if #(.CNT_W(CNT_W)) bus ();

    pipeline_hazard_ctrl #(.MAX_WAIT(MAX_WAIT), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .hz    (bus)
    );

    initial clk = 1'b0;
    // Free-running 10 ns clock.
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Behavioural model: pending = consecutive frozen memory cycles so far.
    int m_pending;
    bit m_err;
    int m_stall;
    int m_flush;
    bit m_frz;
    bit m_lu;

    typedef struct packed {
        logic [4:0] id_rs1;
        logic [4:0] id_rs2;
        logic       use1;
        logic       use2;
        logic [4:0] ex_rs1;
        logic [4:0] ex_rs2;
        logic [4:0] ex_rd;
        logic       ex_wr;
        logic [1:0] src;
        logic       br;
        logic [4:0] me_rd;
        logic       me_wr;
        logic [4:0] wb_rd;
        logic       wb_wr;
        logic [4:0] en;
        logic [1:0] fl;
        logic [1:0] fa;
        logic [1:0] fb;
    } vec_t;

    vec_t vecs [12];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic logic [4:0] dut_en();
        return {bus.pc_en, bus.if_id_en, bus.id_ex_en, bus.ex_me_en, bus.me_wb_en};
    endfunction

    function automatic logic [1:0] dut_fl();
        return {bus.if_id_flush, bus.id_ex_flush};
    endfunction

    function automatic logic [1:0] m_fwd(input int rs, input int mrd, input bit mw,
                                         input int wrd, input bit ww);
        if (rs == 0) return 2'b00;
        if (mw && mrd == rs) return 2'b10;
        if (ww && wrd == rs) return 2'b01;
        return 2'b00;
    endfunction

    task automatic set_quiet();
        bus.id_rs1 = 5'd0; bus.id_rs2 = 5'd0; bus.id_use_rs1 = 1'b0; bus.id_use_rs2 = 1'b0;
        bus.ex_rs1 = 5'd0; bus.ex_rs2 = 5'd0; bus.ex_rd = 5'd0; bus.ex_ru_write = 1'b0;
        bus.ex_ru_data_src = 2'b00; bus.ex_branch_taken = 1'b0;
        bus.me_rd = 5'd0; bus.me_ru_write = 1'b0; bus.me_dm_req = 1'b0; bus.dm_ready = 1'b0;
        bus.wb_rd = 5'd0; bus.wb_ru_write = 1'b0;
    endtask

    task automatic set_load_use();
        set_quiet();
        bus.ex_rd = 5'd5; bus.ex_ru_write = 1'b1; bus.ex_ru_data_src = 2'b01;
        bus.id_rs2 = 5'd5; bus.id_use_rs2 = 1'b1;
    endtask

    // Sample at negedge and compare everything against the model.
    task automatic settle();
        logic [4:0] e_en;
        logic [1:0] e_fl;
        logic [1:0] e_fa;
        logic [1:0] e_fb;
        @(negedge clk);
        m_frz = rst_n && (m_err || (!bus.dm_ready && (m_pending > 0 || bus.me_dm_req)));
        m_lu  = bus.ex_ru_write && bus.ex_ru_data_src == 2'b01 && bus.ex_rd != 5'd0 &&
                ((bus.id_use_rs1 && bus.id_rs1 == bus.ex_rd) ||
                 (bus.id_use_rs2 && bus.id_rs2 == bus.ex_rd));
        if (!rst_n)                   begin e_en = 5'b00000; e_fl = 2'b11; end
        else if (m_frz)               begin e_en = 5'b00000; e_fl = 2'b00; end
        else if (bus.ex_branch_taken) begin e_en = 5'b11111; e_fl = 2'b11; end
        else if (m_lu)                begin e_en = 5'b00111; e_fl = 2'b01; end
        else                          begin e_en = 5'b11111; e_fl = 2'b00; end
        e_fa = rst_n ? m_fwd(bus.ex_rs1, bus.me_rd, bus.me_ru_write, bus.wb_rd, bus.wb_ru_write) : 2'b00;
        e_fb = rst_n ? m_fwd(bus.ex_rs2, bus.me_rd, bus.me_ru_write, bus.wb_rd, bus.wb_ru_write) : 2'b00;
        chk("model_en", 32'(dut_en()), 32'(e_en));
        chk("model_flush", 32'(dut_fl()), 32'(e_fl));
        chk("model_fwd_a", 32'(bus.fwd_a), 32'(e_fa));
        chk("model_fwd_b", 32'(bus.fwd_b), 32'(e_fb));
        chk("model_timeout", 32'(bus.mem_timeout), 32'(m_err));
        chk("model_stall_count", 32'(bus.stall_count), m_stall);
        chk("model_flush_count", 32'(bus.flush_count), m_flush);
    endtask

    // Advance the model by the clock edge about to happen, then cross it.
    task automatic adv();
        if (!rst_n) begin
            m_pending = 0; m_err = 1'b0; m_stall = 0; m_flush = 0;
        end else begin
            if (m_frz || (!bus.ex_branch_taken && m_lu)) m_stall = (m_stall < CNT_SAT) ? m_stall + 1 : CNT_SAT;
            if (!m_frz && bus.ex_branch_taken) m_flush = (m_flush < CNT_SAT) ? m_flush + 1 : CNT_SAT;
            if (!m_err) begin
                if (m_pending > 0) begin
                    if (bus.dm_ready) m_pending = 0;
                    else begin
                        m_pending++;
                        if (m_pending > MAX_WAIT) m_err = 1'b1;
                    end
                end else if (bus.me_dm_req && !bus.dm_ready) begin
                    m_pending = 1;
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic cyc();
        settle();
        adv();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        set_quiet();
        cyc();
        rst_n = 1'b1;
    endtask

    initial begin
        // id_rs1,id_rs2,u1,u2, ex_rs1,ex_rs2,ex_rd,ex_wr,src,br, me_rd,me_wr, wb_rd,wb_wr | en,fl,fa,fb
        vecs[0]  = '{5'd1, 5'd2, 1'b1, 1'b1, 5'd3, 5'd4, 5'd0, 1'b0, 2'b00, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'b11111, 2'b00, 2'b00, 2'b00};
        vecs[1]  = '{5'd1, 5'd5, 1'b0, 1'b1, 5'd3, 5'd4, 5'd5, 1'b1, 2'b01, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'b00111, 2'b01, 2'b00, 2'b00};
        vecs[2]  = '{5'd9, 5'd2, 1'b1, 1'b0, 5'd3, 5'd4, 5'd9, 1'b1, 2'b01, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'b00111, 2'b01, 2'b00, 2'b00};
        vecs[3]  = '{5'd9, 5'd9, 1'b0, 1'b0, 5'd3, 5'd4, 5'd9, 1'b1, 2'b01, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'b11111, 2'b00, 2'b00, 2'b00};
        vecs[4]  = '{5'd9, 5'd2, 1'b1, 1'b0, 5'd3, 5'd4, 5'd9, 1'b1, 2'b00, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'b11111, 2'b00, 2'b00, 2'b00};
        vecs[5]  = '{5'd0, 5'd2, 1'b1, 1'b0, 5'd3, 5'd4, 5'd0, 1'b1, 2'b01, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'b11111, 2'b00, 2'b00, 2'b00};
        vecs[6]  = '{5'd1, 5'd5, 1'b0, 1'b1, 5'd3, 5'd4, 5'd5, 1'b1, 2'b01, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'b11111, 2'b11, 2'b00, 2'b00};
        vecs[7]  = '{5'd1, 5'd2, 1'b0, 1'b0, 5'd7, 5'd7, 5'd0, 1'b0, 2'b00, 1'b0, 5'd7, 1'b1, 5'd7, 1'b1, 5'b11111, 2'b00, 2'b10, 2'b10};
        vecs[8]  = '{5'd1, 5'd2, 1'b0, 1'b0, 5'd7, 5'd7, 5'd0, 1'b0, 2'b00, 1'b0, 5'd7, 1'b0, 5'd7, 1'b1, 5'b11111, 2'b00, 2'b01, 2'b01};
        vecs[9]  = '{5'd1, 5'd2, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 2'b00, 1'b0, 5'd0, 1'b1, 5'd0, 1'b1, 5'b11111, 2'b00, 2'b00, 2'b00};
        vecs[10] = '{5'd1, 5'd2, 1'b0, 1'b0, 5'd3, 5'd4, 5'd0, 1'b0, 2'b00, 1'b0, 5'd4, 1'b1, 5'd3, 1'b1, 5'b11111, 2'b00, 2'b01, 2'b10};
        vecs[11] = '{5'd1, 5'd2, 1'b0, 1'b0, 5'd6, 5'd6, 5'd0, 1'b0, 2'b00, 1'b0, 5'd6, 1'b0, 5'd6, 1'b0, 5'b11111, 2'b00, 2'b00, 2'b00};

        m_pending = 0; m_err = 1'b0; m_stall = 0; m_flush = 0; m_frz = 1'b0; m_lu = 1'b0;

        // Reset: outputs forced even with forwarding/branch-inducing inputs.
        rst_n = 1'b0;
        set_quiet();
        bus.ex_rs1 = 5'd7; bus.me_rd = 5'd7; bus.me_ru_write = 1'b1; bus.ex_branch_taken = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        settle();
        chk("rst_en", 32'(dut_en()), 32'h0);
        chk("rst_flush", 32'(dut_fl()), 32'h3);
        chk("rst_fwd_a", 32'(bus.fwd_a), 32'h0);
        chk("rst_stall_count", 32'(bus.stall_count), 32'h0);
        chk("rst_timeout", 32'(bus.mem_timeout), 32'h0);
        adv();
        rst_n = 1'b1;

        // Table of single-cycle vectors.
        do_reset();
        for (int i = 0; i < 12; i++) begin
            set_quiet();
            bus.id_rs1 = vecs[i].id_rs1; bus.id_rs2 = vecs[i].id_rs2;
            bus.id_use_rs1 = vecs[i].use1; bus.id_use_rs2 = vecs[i].use2;
            bus.ex_rs1 = vecs[i].ex_rs1; bus.ex_rs2 = vecs[i].ex_rs2; bus.ex_rd = vecs[i].ex_rd;
            bus.ex_ru_write = vecs[i].ex_wr; bus.ex_ru_data_src = vecs[i].src;
            bus.ex_branch_taken = vecs[i].br;
            bus.me_rd = vecs[i].me_rd; bus.me_ru_write = vecs[i].me_wr;
            bus.wb_rd = vecs[i].wb_rd; bus.wb_ru_write = vecs[i].wb_wr;
            settle();
            chk($sformatf("vec%0d_en", i), 32'(dut_en()), 32'(vecs[i].en));
            chk($sformatf("vec%0d_flush", i), 32'(dut_fl()), 32'(vecs[i].fl));
            chk($sformatf("vec%0d_fwd_a", i), 32'(bus.fwd_a), 32'(vecs[i].fa));
            chk($sformatf("vec%0d_fwd_b", i), 32'(bus.fwd_b), 32'(vecs[i].fb));
            adv();
        end

        // Load-use lasts one cycle.
        do_reset();
        set_load_use();
        settle();
        chk("lu_en", 32'(dut_en()), 32'h07);
        chk("lu_flush", 32'(dut_fl()), 32'h1);
        adv();
        bus.ex_ru_write = 1'b0;
        settle();
        chk("lu_next_en", 32'(dut_en()), 32'h1f);
        chk("lu_stall_count", 32'(bus.stall_count), 32'd1);
        adv();

        // Memory wait of three cycles.
        do_reset();
        bus.me_dm_req = 1'b1; bus.dm_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            settle();
            chk($sformatf("mw_frozen%0d", i), 32'(dut_en()), 32'h0);
            adv();
        end
        bus.dm_ready = 1'b1;
        settle();
        chk("mw_release_en", 32'(dut_en()), 32'h1f);
        adv();
        set_quiet();
        settle();
        chk("mw_stall_count", 32'(bus.stall_count), 32'd3);
        chk("mw_timeout", 32'(bus.mem_timeout), 32'h0);
        adv();

        // Timeout into ERROR, held until reset.
        do_reset();
        bus.me_dm_req = 1'b1; bus.dm_ready = 1'b0;
        for (int i = 0; i < MAX_WAIT + 1; i++) begin
            settle();
            chk($sformatf("to_frozen%0d", i), 32'(dut_en()), 32'h0);
            chk($sformatf("to_not_yet%0d", i), 32'(bus.mem_timeout), 32'h0);
            adv();
        end
        settle();
        chk("to_timeout_set", 32'(bus.mem_timeout), 32'h1);
        adv();
        bus.me_dm_req = 1'b0; bus.dm_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            settle();
            chk($sformatf("to_error_hold%0d", i), 32'(dut_en()), 32'h0);
            adv();
        end
        rst_n = 1'b0;
        cyc();
        rst_n = 1'b1;
        set_quiet();
        settle();
        chk("to_after_rst_timeout", 32'(bus.mem_timeout), 32'h0);
        chk("to_after_rst_stall", 32'(bus.stall_count), 32'h0);
        chk("to_after_rst_en", 32'(dut_en()), 32'h1f);
        adv();

        // Branch during a load-use match.
        do_reset();
        set_load_use();
        bus.ex_branch_taken = 1'b1;
        settle();
        chk("br_flush", 32'(dut_fl()), 32'h3);
        chk("br_pc_en", 32'(bus.pc_en), 32'h1);
        adv();
        set_quiet();
        settle();
        chk("br_flush_count", 32'(bus.flush_count), 32'd1);
        chk("br_stall_count", 32'(bus.stall_count), 32'd0);
        adv();

        // Saturation of the stall counter.
        do_reset();
        set_load_use();
        repeat (20) cyc();
        set_quiet();
        settle();
        chk("sat_stall_count", 32'(bus.stall_count), 32'(CNT_SAT));
        adv();

        // Randomized traffic against the model.
        for (int i = 0; i < 1500; i++) begin
            rst_n = ($urandom_range(0, 59) != 0);
            bus.id_rs1 = 5'($urandom_range(0, 3));
            bus.id_rs2 = 5'($urandom_range(0, 3));
            bus.id_use_rs1 = 1'($urandom_range(0, 1));
            bus.id_use_rs2 = 1'($urandom_range(0, 1));
            bus.ex_rs1 = 5'($urandom_range(0, 3));
            bus.ex_rs2 = 5'($urandom_range(0, 3));
            bus.ex_rd = 5'($urandom_range(0, 3));
            bus.ex_ru_write = 1'($urandom_range(0, 1));
            bus.ex_ru_data_src = 2'($urandom_range(0, 3));
            bus.ex_branch_taken = ($urandom_range(0, 4) == 0);
            bus.me_rd = 5'($urandom_range(0, 3));
            bus.me_ru_write = 1'($urandom_range(0, 1));
            bus.me_dm_req = 1'($urandom_range(0, 1));
            bus.dm_ready = 1'($urandom_range(0, 1));
            bus.wb_rd = 5'($urandom_range(0, 3));
            bus.wb_ru_write = 1'($urandom_range(0, 1));
            cyc();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
